// File: rtl/ws2812_pkg.sv
// Shared WS2812/SK6812 definitions: receiver FSM states, GRB byte order and
// timing fractions common to the transmitter and receiver.
package ws2812_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_HIGH,
    ST_LOW
  } ws2812_state_t;

  // Byte positions inside the 24-bit word, first byte on the wire is highest.
  localparam int unsigned GRB_G_BYTE = 2;
  localparam int unsigned GRB_R_BYTE = 1;
  localparam int unsigned GRB_B_BYTE = 0;

  localparam int unsigned BIT_RATE_HZ     = 800000;
  localparam int unsigned T0H_PERMILLE    = 250;
  localparam int unsigned THRESH_PERMILLE = 375;
  localparam int unsigned T1H_PERMILLE    = 500;
  localparam int unsigned LATCH_US        = 50;

  function automatic int unsigned frac_cycles(input int unsigned cycles,
                                              input int unsigned permille);
    return (cycles * permille) / 1000;
  endfunction

endpackage

// File: rtl/ws2812_sync_edge.sv
// Two-flop synchronizer for the asynchronous data line plus a history flop
// for rise/fall detection on the synchronized level.
module ws2812_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~hist;
  assign fall  = ~sync & hist;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812/SK6812 frame receiver: decodes GRB pixels and reports frame/bit errors.
// Define WS2812_RX_FORWARD_EN to forward pixels beyond NUM_LEDS on DO.
module ws2812_rx
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS     = 4,
  parameter int SYSTEM_CLOCK = 50000000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        DI,
  output logic                        pixel_valid,
  output logic [$clog2(NUM_LEDS)-1:0] address,
  output logic [7:0]                  red,
  output logic [7:0]                  green,
  output logic [7:0]                  blue,
  output logic                        frame_done,
  output logic                        bit_error,
  output logic                        DO
);

  localparam int unsigned AW          = $clog2(NUM_LEDS);
  localparam int unsigned CYCLE_COUNT = int'(SYSTEM_CLOCK) / BIT_RATE_HZ;
  localparam int unsigned BIT_THRESH  = frac_cycles(CYCLE_COUNT, THRESH_PERMILLE);
  localparam int unsigned LATCH_COUNT = int'(SYSTEM_CLOCK) / (1000000 / LATCH_US);
  localparam int unsigned CW          = $clog2(LATCH_COUNT + 1);

  localparam logic [CW-1:0] CYC_C    = CW'(CYCLE_COUNT);
  localparam logic [CW-1:0] THR_C    = CW'(BIT_THRESH);
  localparam logic [CW-1:0] LATCH_M1 = CW'(LATCH_COUNT - 1);
  localparam logic [AW-1:0] LAST     = AW'(NUM_LEDS - 1);

  logic level, rise, fall;

  ws2812_sync_edge u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (DI),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  ws2812_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [23:0]   shreg;
  logic [4:0]    bit_cnt;
  logic          word_done, inc_pend, full, delivered;
  logic          take_bit, bit_val, gap, stuck, synced;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_SYNC;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    take_bit = 1'b0;
    gap      = 1'b0;
    stuck    = 1'b0;
    synced   = 1'b0;
    bit_val  = (cnt >= THR_C);
    unique case (state)
      ST_SYNC: if (!level && cnt >= LATCH_M1) begin
        synced  = 1'b1;
        state_n = ST_IDLE;
      end
      ST_IDLE: if (rise) state_n = ST_HIGH;
      ST_HIGH: begin
        if (cnt >= CYC_C) begin
          stuck   = 1'b1;
          state_n = ST_SYNC;
        end else if (fall) begin
          take_bit = 1'b1;
          state_n  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (rise) state_n = ST_HIGH;
        else if (cnt >= LATCH_M1) begin
          gap     = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_SYNC;
    endcase
  end

  // Counts are inclusive of the edge cycle, so a count equals the width in clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      unique case (state)
        ST_SYNC: cnt <= (level || synced) ? '0 : cnt + CW'(1);
        ST_IDLE: cnt <= rise ? CW'(1) : '0;
        ST_HIGH: cnt <= take_bit ? CW'(1) : (stuck ? '0 : cnt + CW'(1));
        ST_LOW:  cnt <= rise ? CW'(1) : (gap ? '0 : cnt + CW'(1));
        default: cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      word_done   <= 1'b0;
      inc_pend    <= 1'b0;
      full        <= 1'b0;
      delivered   <= 1'b0;
      address     <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      word_done   <= 1'b0;
      inc_pend    <= 1'b0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      if (take_bit) begin
        shreg <= {shreg[22:0], bit_val};
        if (bit_cnt == 5'd23) begin
          bit_cnt   <= '0;
          word_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end
      if (word_done && !full) begin
        pixel_valid <= 1'b1;
        green       <= shreg[8*GRB_G_BYTE +: 8];
        red         <= shreg[8*GRB_R_BYTE +: 8];
        blue        <= shreg[8*GRB_B_BYTE +: 8];
        delivered   <= 1'b1;
        inc_pend    <= 1'b1;
      end
      if (inc_pend) begin
        if (address == LAST) begin
          address <= '0;
          full    <= 1'b1;
        end else begin
          address <= address + AW'(1);
        end
      end
      if (gap) begin
        bit_cnt    <= '0;
        address    <= '0;
        full       <= 1'b0;
        delivered  <= 1'b0;
        frame_done <= delivered;
        bit_error  <= (bit_cnt != 5'd0);
      end
      if (stuck) begin
        bit_cnt   <= '0;
        address   <= '0;
        full      <= 1'b0;
        delivered <= 1'b0;
        bit_error <= 1'b1;
      end
    end
  end

`ifdef WS2812_RX_FORWARD_EN
  assign DO = full & level;
`else
  assign DO = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboard bench for ws2812_rx: stimulus tasks push expected events, a
// negedge monitor pops and compares whatever the receiver reports.
module tb_ws2812_rx;
  import ws2812_pkg::*;

  localparam int NLED  = 4;
  localparam int CYC   = 62;
  localparam int T0H   = CYC * int'(T0H_PERMILLE) / 1000;
  localparam int T1H   = CYC * int'(T1H_PERMILLE) / 1000;
  localparam int GAP   = 2550;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       DI = 1'b0;
  logic       pixel_valid, frame_done, bit_error, DO;
  logic [1:0] address;
  logic [7:0] red, green, blue;

  ws2812_rx #(.NUM_LEDS(NLED), .SYSTEM_CLOCK(50000000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .DI         (DI),
    .pixel_valid(pixel_valid),
    .address    (address),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_done (frame_done),
    .bit_error  (bit_error),
    .DO         (DO)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_PIX, EV_FRAME, EV_BERR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    int         addr;
    logic [7:0] r, g, b;
  } ev_t;

  ev_t         expq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_fall = 0;
  logic        di_d1 = 1'b0, di_d2 = 1'b0;
  logic        fwd_win = 1'b0;
  logic [23:0] last_rgb = '0;

  // Receiver view of the wire: synced after a gap, pixels seen this frame, bits this frame.
  bit m_sync = 1'b0;
  int m_pix  = 0;
  int m_bits = 0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    di_d1 <= DI;
    di_d2 <= di_d1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input ev_kind_t k);
    ev_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d expected none (t=%0t)", k, $time);
      return;
    end
    e = expq.pop_front();
    chk("event_kind", k, e.kind);
    if (k != e.kind) return;
    case (k)
      EV_PIX: begin
        chk("pix_address", address, e.addr);
        chk("pix_red", red, e.r);
        chk("pix_green", green, e.g);
        chk("pix_blue", blue, e.b);
        chk("pix_latency", cyc - last_fall, 3);
        last_rgb = {e.r, e.g, e.b};
      end
      EV_FRAME: begin
        chk("frame_address", address, 0);
        chk("frame_rgb_hold", {red, green, blue}, last_rgb);
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bit_error)   pop_check(EV_BERR);
      if (frame_done)  pop_check(EV_FRAME);
      if (pixel_valid) pop_check(EV_PIX);
`ifdef WS2812_RX_FORWARD_EN
      chk("do_forward", DO, fwd_win ? di_d2 : 1'b0);
`else
      chk("do_tied_low", DO, 0);
`endif
    end
  end

  task automatic hold(input logic v, input int n);
    DI = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: nominal widths, 1: threshold boundary 22/23, 2: random widths
  task automatic send_bit(input logic b, input int mode);
    int hw;
    case (mode)
      0:       hw = b ? T1H : T0H;
      1:       hw = b ? 23 : 22;
      default: hw = b ? int'($urandom_range(40, 23)) : int'($urandom_range(22, 6));
    endcase
    hold(1'b1, hw);
    last_fall = cyc + 1;
    hold(1'b0, CYC - hw);
  endtask

  task automatic send_pixel(input logic [7:0] g, input logic [7:0] r,
                            input logic [7:0] b, input int mode);
    logic [23:0] w;
    ev_t e;
    w = {g, r, b};
    if (m_sync) begin
      if (m_pix < NLED) begin
        e.kind = EV_PIX; e.addr = m_pix; e.r = r; e.g = g; e.b = b;
        expq.push_back(e);
      end
      fwd_win = (m_pix >= NLED);
      m_pix++;
      m_bits += 24;
    end
    for (int i = 23; i >= 0; i--) send_bit(w[i], mode);
    fwd_win = 1'b0;
  endtask

  task automatic send_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(1, 0)), 2);
    if (m_sync) m_bits += n;
  endtask

  task automatic send_gap();
    ev_t e;
    if (m_sync) begin
      e.addr = 0; e.r = '0; e.g = '0; e.b = '0;
      if (m_bits % 24 != 0) begin e.kind = EV_BERR;  expq.push_back(e); end
      if (m_pix > 0)        begin e.kind = EV_FRAME; expq.push_back(e); end
    end
    m_sync = 1'b1;
    m_pix  = 0;
    m_bits = 0;
    hold(1'b0, GAP);
  endtask

  task automatic send_stuck();
    ev_t e;
    if (m_sync) begin
      e.kind = EV_BERR; e.addr = 0; e.r = '0; e.g = '0; e.b = '0;
      expq.push_back(e);
    end
    m_sync = 1'b0;
    m_pix  = 0;
    m_bits = 0;
    hold(1'b1, 70);
    hold(1'b0, 30);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    DI      = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_bit_error", bit_error, 0);
    chk("rst_address", address, 0);
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_do", DO, 0);
    reset_n  = 1'b1;
    m_sync   = 1'b0;
    m_pix    = 0;
    m_bits   = 0;
    last_rgb = '0;
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset(5);
    send_gap();

    // Single fixed pixel, nominal widths.
    send_pixel(8'h12, 8'h34, 8'h56, 0);
    send_gap();

    // Full frame of four.
    for (int i = 0; i < NLED; i++)
      send_pixel(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                 8'($urandom_range(255, 0)), 0);
    send_gap();

    // Five pixels: the fifth is suppressed and forwarded.
    for (int i = 0; i < NLED + 1; i++)
      send_pixel(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                 8'($urandom_range(255, 0)), 2);
    send_gap();

    // Threshold boundary widths.
    send_pixel(8'hA5, 8'h5A, 8'hC3, 1);
    send_pixel(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
               8'($urandom_range(255, 0)), 1);
    send_gap();

    // Truncated pixel, then recovery at address 0.
    send_bits(10);
    send_gap();
    send_pixel(8'h01, 8'h80, 8'hFF, 0);
    send_gap();

    // Stuck-high, ignored pixel while resyncing, then recovery.
    send_bits(5);
    send_stuck();
    send_pixel(8'hFF, 8'hFF, 8'hFF, 0);
    send_gap();
    send_pixel(8'h3C, 8'hC3, 8'h99, 0);
    send_gap();

    // Reset mid-frame: nothing until a full gap.
    send_bits(10);
    do_reset(3);
    send_bits(14);
    send_pixel(8'h77, 8'h66, 8'h55, 0);
    send_gap();
    send_pixel(8'h10, 8'h20, 8'h30, 2);
    send_gap();

    // Random frames, optionally ending in a partial pixel.
    for (int f = 0; f < 2; f++) begin
      int np;
      np = int'($urandom_range(6, 1));
      for (int i = 0; i < np; i++)
        send_pixel(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)),
                   8'($urandom_range(255, 0)), 2);
      if ($urandom_range(1, 0) == 1) send_bits(int'($urandom_range(23, 1)));
      send_gap();
    end

    hold(1'b0, 20);
    chk("queue_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter NUM_LEDS, default 4: number of pixels captured per frame; address width $clog2(NUM_LEDS).
REQ-002 Parameter SYSTEM_CLOCK, default 50000000: clk frequency in Hz; all timing thresholds are derived from it.
REQ-003 clk  input  1  sole clock; all logic is on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 DI  input  1  asynchronous WS2812/SK6812 serial data line.
REQ-006 pixel_valid  output  1  one-cycle pulse; address/red/green/blue hold a complete pixel.
REQ-007 address  output  $clog2(NUM_LEDS)  index of the pixel presented, 0 = first pixel after a latch gap.
REQ-008 red, green, blue  output  8 each  decoded colour bytes, MSB first on the wire, wire order G,R,B.
REQ-009 frame_done  output  1  one-cycle pulse when a latch gap ends a frame that delivered at least one pixel.
REQ-010 bit_error  output  1  one-cycle pulse on a malformed symbol.
REQ-011 DO  output  1  forwarded data line (see Configuration).

Function
REQ-012 CYCLE_COUNT = SYSTEM_CLOCK/800000; BIT_THRESH = 0.375*CYCLE_COUNT; LATCH_COUNT = SYSTEM_CLOCK/20000 (50 us); all integer-truncated.
REQ-013 DI passes through a 2-flop synchronizer plus 1 history flop; rise/fall are detected from the synchronized signal only.
REQ-014 States: SYNC (wait for latch gap), IDLE (gap seen, wait for rise), HIGH (count high time), LOW (count low time).
REQ-015 After reset the state is SYNC; SYNC goes to IDLE after DI stays low for LATCH_COUNT consecutive cycles; a high during SYNC restarts the count.
REQ-016 IDLE goes to HIGH on a rise; the high counter clears on entry and saturates at CYCLE_COUNT.
REQ-017 On a fall in HIGH: bit = 1 if high count >= BIT_THRESH, else 0; the bit shifts into a 24-bit register and the FSM goes to LOW.
REQ-018 In LOW, a rise goes to HIGH; a low count reaching LATCH_COUNT goes to IDLE, resets address to 0, clears the bit count, and pulses frame_done if at least one pixel was delivered since the previous gap.
REQ-019 On the 24th bit, red/green/blue load from the shift register and pixel_valid pulses 3 clk after the fall is sampled in the first synchronizer flop; address then increments.
REQ-020 When the pixel at address NUM_LEDS-1 is delivered, the address wraps to 0 and further pixels in the frame are not presented (pixel_valid stays low) until the next latch gap.
REQ-021 A high count reaching CYCLE_COUNT, or a latch gap arriving with a non-zero, non-multiple-of-24 bit count, pulses bit_error, discards the partial pixel, and goes to SYNC (a stuck high) or IDLE (a truncated pixel).
REQ-022 red, green and blue hold their values between pixel_valid pulses.

Reset
REQ-023 While reset_n is low: state=SYNC, counters=0, address=0, red=green=blue=0, pixel_valid=frame_done=bit_error=0, DO=0, synchronizer flops=0.
REQ-024 Deasserting reset_n mid-frame yields no pixel until a full latch gap is observed.

Configuration
REQ-025 Macro WS2812_RX_FORWARD_EN defined: DO drives the synchronized DI (2-cycle delay) only for pixels after the NUM_LEDS-th in a frame, otherwise low, so the block behaves as a chain element.
REQ-026 Macro WS2812_RX_FORWARD_EN undefined: DO is tied to 0 and the forwarding logic is absent.

Structure
REQ-027 A shared package ws2812_pkg holds the FSM state encodings, the GRB byte-order constants, and the timing-fraction constants (0.25, 0.375, 0.5, latch time) shared with the transmitter.
REQ-028 The synchronizer/edge detector is a sub-module, ws2812_sync_edge (outputs: level, rise, fall).

Verification (SYSTEM_CLOCK=50 MHz: CYCLE=62, BIT_THRESH=23, LATCH=2500; NUM_LEDS=4)
REQ-029 Reset, hold DI low 2500 clk, send G=0x12 R=0x34 B=0x56 (high 15 clk = 0, high 31 clk = 1, period 62) -> one pixel_valid, address=0, red=0x34, green=0x12, blue=0x56.
REQ-030 Send 4 pixels then a 2500-clk low gap -> pixel_valid at addresses 0,1,2,3, then one frame_done, then address=0.
REQ-031 Send 5 pixels with WS2812_RX_FORWARD_EN defined -> 4 pixel_valid pulses; DO replays the 5th pixel's waveform delayed by 2 clk; with the macro undefined, DO stays 0.
REQ-032 Hold DI high 62 clk mid-pixel -> bit_error pulse, no pixel_valid, state SYNC until a 2500-clk low gap.
REQ-033 Send 10 bits then a 2500-clk low gap -> bit_error pulse, no pixel_valid, no frame_done; the next full pixel arrives at address 0.
REQ-034 High widths of 22 and 23 clk -> decoded bits 0 and 1 respectively (threshold boundary).
